efm_pipe_acc: RTL and testbench
===============================

Name: efm_pipe_acc

Overview:
- Pipelined first-order error-feedback accumulator (EFM1), the stage that consumes the 4-bit lookahead-carry adder slices in the MASH delta-sigma modulator.
- Splits a WIDTH-bit accumulator into 4-bit slices, one pipeline stage per slice, with registered inter-slice carries, input skew and output deskew.
- Emits a 1-bit overflow (carry) stream to the noise-cancellation network and a residue to the next MASH stage.
- Arithmetically equivalent to a non-pipelined accumulator: acc <= (acc + x) mod 2^WIDTH, carry = overflow, delayed by NSLICE enabled cycles.

Parameters:
- WIDTH, 16, accumulator/input width; must be a multiple of 4 and at least 8.
- NSLICE, WIDTH/4, number of 4-bit slices and pipeline depth. Derived; not overridden.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset; synchronous, active-high
- i_en  in  1  clock enable / sample strobe; pipeline advances only on cycles with i_en=1
- i_x  in  WIDTH  unsigned input increment (frequency control word fraction)
- o_carry  out  1  overflow of the aligned sample
- o_err  out  WIDTH  accumulator residue after the aligned sample (feeds next MASH stage)
- o_valid  out  1  o_carry/o_err updated this cycle with a fully-propagated sample

Behaviour:
- Reset (i_rst=1 at an edge): all slice accumulators, inter-slice carry regs, skew/deskew regs, fill counter, o_carry, o_err and o_valid clear to 0. Reset has priority over i_en. Reset mid-operation discards all in-flight samples, and refill restarts from zero.
- Slice k (0..NSLICE-1) operates on bits [4k+3:4k]:
  - Its input is i_x slice k delayed by k enabled cycles (skew registers).
  - On an enabled edge: acc_k <= acc_k + xskew_k + cin_k (4-bit wrap); cout_k register <= carry out of that sum.
  - cin_0 = 0. cin_k = registered cout_{k-1}.
  - The slice adder is a 4-bit lookahead-carry sum with carry-in.
- Deskew: the slice k result passes through NSLICE-1-k additional enabled-cycle registers before o_err[4k+3:4k]. The top slice drives o_err directly from acc_{NSLICE-1}.
- o_carry = registered cout_{NSLICE-1}.
- Latency: a sample presented with i_en=1 at enabled edge E0 appears on o_carry/o_err after enabled edge E(NSLICE-1), i.e. NSLICE enabled edges.
- Fill counter: counts enabled edges since reset and saturates at NSLICE.
  - On an enabled edge: o_valid <= (cnt >= NSLICE-1).
  - On a disabled edge: o_valid <= 0.
  - o_valid is therefore 0 for the first NSLICE-1 enabled edges after reset.
- i_en=0: every register holds, including o_carry and o_err. Only o_valid drops. Stalls never lose or duplicate samples, and the alignment of carries across slices is preserved.
- Wrap-around: the accumulator wraps mod 2^WIDTH. Carry propagation across all slices is handled by the pipeline, with no combinational path longer than one 4-bit slice plus a register.
- Long-run o_carry density = i_x / 2^WIDTH exactly, for a constant i_x.

Decomposition:
- Shared package (ddsm_pkg): SLICE_W = 4 and a function giving NSLICE from WIDTH; reused by the later MASH stages and the noise-cancellation network.
- Sub-module efm_acc_slice: 4-bit accumulator register, lookahead add with carry-in, registered carry out, enable, synchronous reset. efm_pipe_acc instantiates NSLICE of these plus generate-loop skew/deskew shift registers and the fill counter.

Test Plan (all cases WIDTH=16, NSLICE=4):
- Reset, then i_en=1, constant i_x=0x4000 -> o_valid first high after the 4th enabled edge; o_err sequence 0x4000, 0x8000, 0xC000, 0x0000 repeating; o_carry 0,0,0,1 repeating.
- Full-width carry ripple: i_x=0xFFFF then 0x0001 -> outputs 0xFFFF/carry 0, then 0x0000/carry 1. This proves carry crosses all 4 slices through the pipeline.
- i_x=0xFFFF constant -> o_err 0xFFFF, 0xFFFE, 0xFFFD, ...; o_carry 0 then 1 on every later sample.
- Stall: i_x=0x4000 with i_en toggling 1,0,0,1,... -> o_valid high only on edges following enabled cycles; o_err/o_carry sequence identical to continuous case; values held during stalls.
- Reset mid-stream: after 6 samples of 0x1234, assert i_rst for 1 cycle -> all outputs 0, and o_valid low for the next 3 enabled edges. Post-refill outputs match a fresh run (0x1234, 0x2468, ...).
- Random i_x, random i_en, 10k samples -> o_err/o_carry match a non-pipelined reference accumulator delayed 4 enabled samples; carry count equals floor(sum(i_x)/2^16).

Source files
------------

// File: rtl/ddsm_pkg.sv
// Shared constants and helpers for the MASH delta-sigma modulator datapath.
// Latency: n/a (package only).
// Backpressure: n/a; stages stall through their own clock-enable inputs.
package ddsm_pkg;

    // Width of one lookahead-carry adder slice; one pipeline stage per slice.
    localparam int SLICE_W = 4;

    // Number of slices (and pipeline depth) for an accumulator of the given width.
    function automatic int nslice_of(input int width);
        return width / SLICE_W;
    endfunction

endpackage

// File: rtl/efm_acc_slice.sv
// One 4-bit slice of the pipelined accumulator: lookahead add with carry-in, registered sum and carry.
// Latency: 1 enabled cycle from i_x/i_cin to o_acc/o_cout.
// Backpressure: none; i_en=0 holds both registers, i_rst (sync, active-high) clears them with priority.
//
// Ports: i_clk, i_rst, i_en; i_x slice addend; i_cin carry from the slice below (already registered);
//        o_acc slice accumulator register; o_cout registered carry out of the last add.
module efm_acc_slice
    import ddsm_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_en,
    input  logic [SLICE_W-1:0] i_x,
    input  logic               i_cin,
    output logic [SLICE_W-1:0] o_acc,
    output logic               o_cout
);

    logic [SLICE_W-1:0] r_acc;
    logic               r_cout;

    logic [SLICE_W-1:0] w_g;
    logic [SLICE_W-1:0] w_p;
    logic [SLICE_W:0]   w_c;
    logic [SLICE_W-1:0] w_sum;

    // Generate/propagate terms; every carry is a flat two-level expression
    // so the slice's critical path does not ripple through the bits.
    assign w_g = r_acc & i_x;
    assign w_p = r_acc ^ i_x;

    assign w_c[0] = i_cin;
    assign w_c[1] = w_g[0] | (w_p[0] & i_cin);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_cin);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & i_cin);
    assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_cin);

    assign w_sum = w_p ^ w_c[SLICE_W-1:0];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_acc  <= '0;
            r_cout <= 1'b0;
        end else if (i_en) begin
            r_acc  <= w_sum;
            r_cout <= w_c[SLICE_W];
        end
    end

    assign o_acc  = r_acc;
    assign o_cout = r_cout;

endmodule

// File: rtl/efm_pipe_acc.sv
// Pipelined first-order error-feedback accumulator (EFM1): acc <= (acc + x) mod 2^WIDTH, carry = overflow.
// Latency: NSLICE enabled cycles from i_x to o_carry/o_err.
// Backpressure: none; i_en=0 freezes the whole pipeline (outputs hold), only o_valid drops.
//
// Ports: i_clk, i_rst (sync, active-high), i_en sample strobe, i_x increment;
//        o_carry overflow bit, o_err residue to next MASH stage, o_valid fresh aligned sample.
// WIDTH must be a multiple of 4 and at least 8.
module efm_pipe_acc
    import ddsm_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_x,
    output logic             o_carry,
    output logic [WIDTH-1:0] o_err,
    output logic             o_valid
);

    localparam int NSLICE = nslice_of(WIDTH);
    localparam int CNT_W  = $clog2(NSLICE + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(NSLICE);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NSLICE - 1);

    logic [NSLICE-1:0] w_cout;
    logic [WIDTH-1:0]  w_acc;
    logic [WIDTH-1:0]  w_err;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_valid;

    for (genvar k = 0; k < NSLICE; k++) begin : g_slice
        logic [SLICE_W-1:0] w_xin;
        logic               w_cin;

        // Input skew: slice k sees its part of a sample k enabled cycles late,
        // exactly when the carry from that sample's lower slices arrives.
        if (k == 0) begin : g_noskew
            assign w_xin = i_x[SLICE_W-1:0];
            assign w_cin = 1'b0;
        end else begin : g_skew
            logic [SLICE_W-1:0] r_sk [k];

            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    for (int j = 0; j < k; j++) r_sk[j] <= '0;
                end else if (i_en) begin
                    r_sk[0] <= i_x[k*SLICE_W +: SLICE_W];
                    for (int j = 1; j < k; j++) r_sk[j] <= r_sk[j-1];
                end
            end

            assign w_xin = r_sk[k-1];
            assign w_cin = w_cout[k-1];
        end

        efm_acc_slice u_slice (
            .i_clk  (i_clk),
            .i_rst  (i_rst),
            .i_en   (i_en),
            .i_x    (w_xin),
            .i_cin  (w_cin),
            .o_acc  (w_acc[k*SLICE_W +: SLICE_W]),
            .o_cout (w_cout[k])
        );

        // Output deskew: lower slices finish earlier, so they wait the remaining
        // NSLICE-1-k enabled cycles to line up with the top slice and its carry.
        if (k == NSLICE - 1) begin : g_nodeskew
            assign w_err[k*SLICE_W +: SLICE_W] = w_acc[k*SLICE_W +: SLICE_W];
        end else begin : g_deskew
            localparam int D = NSLICE - 1 - k;
            logic [SLICE_W-1:0] r_dsk [D];

            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    for (int j = 0; j < D; j++) r_dsk[j] <= '0;
                end else if (i_en) begin
                    r_dsk[0] <= w_acc[k*SLICE_W +: SLICE_W];
                    for (int j = 1; j < D; j++) r_dsk[j] <= r_dsk[j-1];
                end
            end

            assign w_err[k*SLICE_W +: SLICE_W] = r_dsk[D-1];
        end
    end

    // Fill counter: outputs only carry a real sample once NSLICE enabled edges
    // have pushed one all the way through; saturates so it never wraps.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt   <= '0;
            r_valid <= 1'b0;
        end else if (i_en) begin
            if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
            r_valid <= (r_cnt >= CNT_FULL);
        end else begin
            r_valid <= 1'b0;
        end
    end

    assign o_carry = w_cout[NSLICE-1];
    assign o_err   = w_err;
    assign o_valid = r_valid;

endmodule

// File: tb/tb_efm_pipe_acc.sv
module tb_efm_pipe_acc;

    logic        clk;
    logic        rst;
    logic        en;
    logic [15:0] x;
    logic        o_carry;
    logic [15:0] o_err;
    logic        o_valid;

    int vectors    = 0;
    int miscompares = 0;
    int dut_carries = 0;

    efm_pipe_acc #(.WIDTH(16)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_en    (en),
        .i_x     (x),
        .o_carry (o_carry),
        .o_err   (o_err),
        .o_valid (o_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    // Reference: a plain single-cycle accumulator; each result is released
    // once four enabled samples have been taken (one per pipeline stage).
    logic [16:0] q_res[$];
    logic [15:0] m_acc   = '0;
    logic        m_valid = 1'b0;
    logic        m_carry = 1'b0;
    logic [15:0] m_err   = '0;

    always @(posedge clk) begin
        logic [16:0] s;
        if (rst) begin
            m_acc   = '0;
            q_res.delete();
            m_valid = 1'b0;
            m_carry = 1'b0;
            m_err   = '0;
        end else if (en) begin
            s     = {1'b0, m_acc} + {1'b0, x};
            m_acc = s[15:0];
            q_res.push_back(s);
            if (q_res.size() == 4) begin
                s       = q_res.pop_front();
                m_carry = s[16];
                m_err   = s[15:0];
                m_valid = 1'b1;
            end else begin
                m_valid = 1'b0;
            end
        end else begin
            m_valid = 1'b0;
        end
        #1;
        chk("model_valid", {31'b0, o_valid}, {31'b0, m_valid});
        chk("model_carry", {31'b0, o_carry}, {31'b0, m_carry});
        chk("model_err",   {16'b0, o_err},   {16'b0, m_err});
        if (o_valid && o_carry) dut_carries++;
    end

    task automatic step(input logic r, input logic e, input logic [15:0] xv);
        @(negedge clk);
        rst = r;
        en  = e;
        x   = xv;
        @(posedge clk);
        #2;
    endtask

    initial begin
        logic [15:0] t1_err [5];
        logic        t1_c   [5];
        longint      sum_x;
        int          c0;
        logic        e;
        logic [15:0] xv;

        rst = 1'b1;
        en  = 1'b0;
        x   = '0;

        // Reset state
        step(1, 0, 16'h0);
        chk("rst_valid", {31'b0, o_valid}, 32'd0);
        chk("rst_carry", {31'b0, o_carry}, 32'd0);
        chk("rst_err",   {16'b0, o_err},   32'd0);

        // Constant 0x4000: 4000,8000,C000,0000 with carry on the wrap
        t1_err = '{16'h4000, 16'h8000, 16'hC000, 16'h0000, 16'h4000};
        t1_c   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 1; i <= 8; i++) begin
            step(0, 1, 16'h4000);
            chk("t1_valid", {31'b0, o_valid}, (i >= 4) ? 32'd1 : 32'd0);
            if (i >= 4) begin
                chk("t1_err",   {16'b0, o_err},   {16'b0, t1_err[i-4]});
                chk("t1_carry", {31'b0, o_carry}, {31'b0, t1_c[i-4]});
            end
        end

        // Full-width carry ripple: FFFF then 0001
        step(1, 0, 16'h0);
        step(0, 1, 16'hFFFF);
        step(0, 1, 16'h0001);
        step(0, 1, 16'h0000);
        step(0, 1, 16'h0000);
        chk("t2_err0",   {16'b0, o_err},   32'h0000FFFF);
        chk("t2_carry0", {31'b0, o_carry}, 32'd0);
        step(0, 1, 16'h0000);
        chk("t2_err1",   {16'b0, o_err},   32'h00000000);
        chk("t2_carry1", {31'b0, o_carry}, 32'd1);

        // Constant FFFF: FFFF, FFFE, FFFD with carry after the first
        step(1, 0, 16'h0);
        for (int i = 1; i <= 6; i++) begin
            step(0, 1, 16'hFFFF);
            if (i >= 4) begin
                chk("t3_err",   {16'b0, o_err},   {16'b0, 16'hFFFF - 16'(i - 4)});
                chk("t3_carry", {31'b0, o_carry}, (i >= 5) ? 32'd1 : 32'd0);
            end
        end

        // Stall: enable on every third cycle
        step(1, 0, 16'h0);
        for (int i = 0; i <= 12; i++) begin
            step(0, (i % 3) == 0, 16'h4000);
            if (i == 9) begin
                chk("t4_valid9", {31'b0, o_valid}, 32'd1);
                chk("t4_err9",   {16'b0, o_err},   32'h00004000);
            end
            if (i == 10 || i == 11) begin
                chk("t4_validhold", {31'b0, o_valid}, 32'd0);
                chk("t4_errhold",   {16'b0, o_err},   32'h00004000);
            end
            if (i == 12) chk("t4_err12", {16'b0, o_err}, 32'h00008000);
        end

        // Reset mid-stream, then refill from scratch
        step(1, 0, 16'h0);
        for (int i = 0; i < 6; i++) step(0, 1, 16'h1234);
        step(1, 1, 16'h1234);
        chk("t5_rst_err",   {16'b0, o_err},   32'd0);
        chk("t5_rst_carry", {31'b0, o_carry}, 32'd0);
        chk("t5_rst_valid", {31'b0, o_valid}, 32'd0);
        for (int i = 1; i <= 5; i++) begin
            step(0, 1, 16'h1234);
            chk("t5_valid", {31'b0, o_valid}, (i >= 4) ? 32'd1 : 32'd0);
            if (i == 4) chk("t5_err4", {16'b0, o_err}, 32'h00001234);
            if (i == 5) chk("t5_err5", {16'b0, o_err}, 32'h00002468);
        end

        // Random increments with random stalls; carry count against the sum
        step(1, 0, 16'h0);
        c0    = dut_carries;
        sum_x = 0;
        for (int i = 0; i < 10000; i++) begin
            e  = ($urandom_range(0, 9) < 7);
            xv = 16'($urandom);
            if (e) sum_x += longint'(xv);
            step(0, e, xv);
        end
        for (int i = 0; i < 4; i++) step(0, 1, 16'h0000);
        chk("t6_carry_count", 32'(dut_carries - c0), 32'(sum_x >> 16));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
